// File: rtl/neuron_mac_lanes.sv
// Sequential multi-lane MAC neuron: dot(a, w) + bias with Q-format rescale,
// selectable activation, saturation and a ready/valid output handshake.
module neuron_mac_lanes #(
  parameter int INPUT_WIDTH = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int LANES       = 2,
  parameter int FRAC_BITS   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a_in [INPUT_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] w_in [INPUT_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic        [1:0]            act_sel,
  input  logic                         valid_in,
  output logic                         in_ready,
  output logic                         valid_out,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         sat_flag
);

  localparam int IDX_W = $clog2(INPUT_WIDTH + LANES) + 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (LANES < 1 || LANES > INPUT_WIDTH) begin : g_bad_lanes
    $error("neuron_mac_lanes: LANES must be in 1..INPUT_WIDTH");
  end
  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(INPUT_WIDTH) + 1) begin : g_bad_acc
    $error("neuron_mac_lanes: ACC_WIDTH too small for a wrap-free sum");
  end

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    BIAS,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0]   a_reg [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0]   w_reg [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0]   bias_reg;
  logic        [1:0]              act_reg;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic        [IDX_W-1:0]        idx;

  logic                           last_mac;
  logic signed [ACC_WIDTH-1:0]    mac_sum;
  logic signed [DATA_WIDTH-1:0]   lane_a;
  logic signed [DATA_WIDTH-1:0]   lane_w;
  logic signed [2*DATA_WIDTH-1:0] lane_prod;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    scaled;
  logic signed [ACC_WIDTH-1:0]    activated;
  logic signed [DATA_WIDTH-1:0]   result;
  logic                           result_sat;

  assign in_ready = (state == IDLE);
  assign last_mac = (int'(idx) + LANES >= INPUT_WIDTH);
  assign bias_ext = ACC_WIDTH'(bias_reg) <<< FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_in)               state_nxt = MAC;
      MAC:  if (last_mac)               state_nxt = BIAS;
      BIAS:                             state_nxt = OUT;
      OUT:  if (valid_out && out_ready) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Each lane muxes its operand pair by constant index; lanes past the end stay 0.
  always_comb begin
    mac_sum   = '0;
    lane_a    = '0;
    lane_w    = '0;
    lane_prod = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_a = '0;
      lane_w = '0;
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (int'(idx) + k == i) begin
          lane_a = a_reg[i];
          lane_w = w_reg[i];
        end
      end
      lane_prod = lane_a * lane_w;
      mac_sum   = mac_sum + ACC_WIDTH'(lane_prod);
    end
  end

  always_comb begin
    scaled     = acc >>> FRAC_BITS;
    activated  = scaled;
    result     = '0;
    result_sat = 1'b0;
    if (scaled < 0) begin
      if (act_reg == 2'b01)      activated = '0;
      else if (act_reg == 2'b10) activated = scaled >>> 3;
    end
    if (activated > SAT_MAX) begin
      result     = SAT_MAX[DATA_WIDTH-1:0];
      result_sat = 1'b1;
    end else if (activated < SAT_MIN) begin
      result     = SAT_MIN[DATA_WIDTH-1:0];
      result_sat = 1'b1;
    end else begin
      result     = activated[DATA_WIDTH-1:0];
    end
  end

  // The OUT load happens on the first OUT cycle, so valid_out itself marks it done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        a_reg[i] <= '0;
        w_reg[i] <= '0;
      end
      bias_reg  <= '0;
      act_reg   <= '0;
      acc       <= '0;
      idx       <= '0;
      a_out     <= '0;
      sat_flag  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            a_reg    <= a_in;
            w_reg    <= w_in;
            bias_reg <= bias;
            act_reg  <= act_sel;
            acc      <= '0;
            idx      <= '0;
          end
        end
        MAC: begin
          acc <= acc + mac_sum;
          idx <= idx + IDX_W'(LANES);
        end
        BIAS: acc <= acc + bias_ext;
        OUT: begin
          if (!valid_out) begin
            a_out     <= result;
            sat_flag  <= result_sat;
            valid_out <= 1'b1;
          end else if (out_ready) begin
            valid_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Scoreboard bench for neuron_mac_lanes: a 5-input 2-lane integer instance and
// a 2-input 1-lane Q8 instance, checked against a behavioural model.
module tb_neuron_mac_lanes;

  typedef logic signed [15:0] vec_t [5];
  typedef struct {
    longint y;
    logic   s;
  } exp_t;

  localparam int NCYC  = (5 + 2 - 1) / 2;
  localparam int QNCYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic signed [15:0] a_in [5];
  logic signed [15:0] w_in [5];
  logic signed [15:0] bias;
  logic        [1:0]  act_sel;
  logic               valid_in;
  logic               in_ready;
  logic               valid_out;
  logic               out_ready;
  logic signed [15:0] a_out;
  logic               sat_flag;

  logic signed [15:0] q_a [2];
  logic signed [15:0] q_w [2];
  logic signed [15:0] q_bias;
  logic        [1:0]  q_act;
  logic               q_valid_in;
  logic               q_in_ready;
  logic               q_valid_out;
  logic               q_out_ready;
  logic signed [15:0] q_a_out;
  logic               q_sat;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  neuron_mac_lanes #(
    .INPUT_WIDTH(5), .DATA_WIDTH(16), .ACC_WIDTH(48), .LANES(2), .FRAC_BITS(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .w_in(w_in), .bias(bias),
    .act_sel(act_sel), .valid_in(valid_in), .in_ready(in_ready),
    .valid_out(valid_out), .out_ready(out_ready), .a_out(a_out), .sat_flag(sat_flag)
  );

  neuron_mac_lanes #(
    .INPUT_WIDTH(2), .DATA_WIDTH(16), .ACC_WIDTH(48), .LANES(1), .FRAC_BITS(8)
  ) u_q8 (
    .clk(clk), .rst_n(rst_n), .a_in(q_a), .w_in(q_w), .bias(q_bias),
    .act_sel(q_act), .valid_in(q_valid_in), .in_ready(q_in_ready),
    .valid_out(q_valid_out), .out_ready(q_out_ready), .a_out(q_a_out), .sat_flag(q_sat)
  );

  function automatic longint model(input vec_t a, input vec_t w, input longint b,
                                   input logic [1:0] act, input int frac, input int n,
                                   output logic sat);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(a[i]) * longint'(w[i]);
    acc += b * (longint'(1) << frac);
    r = acc >>> frac;
    if (r < 0 && act == 2'b01) r = 0;
    else if (r < 0 && act == 2'b10) r = r >>> 3;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 5; i++) begin
      a_in[i] = 16'($urandom);
      w_in[i] = 16'($urandom);
    end
    bias    = 16'($urandom);
    act_sel = 2'($urandom);
  endtask

  task automatic applyStimulus(input vec_t a, input vec_t w, input int b, input logic [1:0] act);
    exp_t e;
    int   waited;
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 0, 1);
    a_in     = a;
    w_in     = w;
    bias     = 16'(b);
    act_sel  = act;
    valid_in = 1'b1;
    e.y = model(a, w, longint'(b), act, 0, 5, e.s);
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    scramble();
  endtask

  task automatic collectResult(input string tag, input int hold);
    exp_t   e;
    int     lat;
    longint held;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!valid_out && lat < 40);
    checkOutput({tag, "_latency"}, lat, NCYC + 2);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_a_out"}, a_out, e.y);
    checkOutput({tag, "_sat"}, sat_flag, e.s);
    held = a_out;
    for (int c = 0; c < hold; c++) begin
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      scramble();
      checkOutput({tag, "_hold_valid"}, valid_out, 1);
      checkOutput({tag, "_hold_a_out"}, a_out, held);
      checkOutput({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_hs_valid"}, valid_out, 0);
    checkOutput({tag, "_hs_in_ready"}, in_ready, 1);
    checkOutput({tag, "_hs_a_out_kept"}, a_out, held);
  endtask

  initial begin
    vec_t a;
    vec_t w;
    vec_t qa;
    vec_t qw;
    logic qs;
    longint qy;
    int   lat;

    valid_in    = 1'b0;
    out_ready   = 1'b0;
    q_valid_in  = 1'b0;
    q_out_ready = 1'b1;
    q_a[0] = '0; q_a[1] = '0; q_w[0] = '0; q_w[1] = '0;
    q_bias = '0;
    q_act  = '0;
    scramble();

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_a_out", a_out, 0);
    checkOutput("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    a = '{16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd0};
    w = '{16'sd5, 16'sd6, 16'sd7, 16'sd0, 16'sd0};
    applyStimulus(a, w, 10, 2'b00);
    collectResult("dot3", 0);
    checkOutput("dot3_const", sat_flag == 1'b0 ? a_out : 16'sd0, 66);

    a = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};
    w = '{16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6};
    applyStimulus(a, w, 20, 2'b00);
    collectResult("odd_lane", 0);
    checkOutput("odd_lane_const", a_out, 90);

    a = '{-16'sd5, 16'sd3, -16'sd2, 16'sd0, 16'sd0};
    w = '{16'sd4, 16'sd2, 16'sd3, 16'sd0, 16'sd0};
    for (int act = 0; act < 4; act++) begin
      applyStimulus(a, w, 0, 2'(act));
      collectResult($sformatf("act%0d", act), 0);
    end

    a = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd0, 16'sd0};
    w = a;
    applyStimulus(a, w, 0, 2'b00);
    collectResult("sat_pos", 0);
    a = '{-16'sd32767, -16'sd32767, -16'sd32767, 16'sd0, 16'sd0};
    applyStimulus(a, w, 0, 2'b00);
    collectResult("sat_neg", 0);
    applyStimulus(a, w, 0, 2'b01);
    collectResult("sat_neg_relu", 0);
    applyStimulus(a, w, 0, 2'b10);
    collectResult("sat_neg_leaky", 0);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 5; i++) begin
        a[i] = (n < 4) ? 16'($urandom_range(0, 2000) - 1000) : 16'($urandom);
        w[i] = (n < 4) ? 16'($urandom_range(0, 2000) - 1000) : 16'($urandom);
      end
      applyStimulus(a, w, int'($urandom_range(0, 60000)) - 30000, 2'($urandom_range(0, 3)));
      collectResult($sformatf("rand%0d", n), n % 3);
    end

    a = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd0};
    w = a;
    applyStimulus(a, w, 0, 2'b00);
    collectResult("backpressure", 4);
    @(posedge clk);
    #1;
    checkOutput("no_queue_in_ready", in_ready, 1);
    checkOutput("no_queue_valid", valid_out, 0);

    a = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};
    w = '{16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6};
    applyStimulus(a, w, 20, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", valid_out, 0);
    checkOutput("midrst_a_out", a_out, 0);
    checkOutput("midrst_sat", sat_flag, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_idle_valid", valid_out, 0);
    applyStimulus(a, w, 20, 2'b00);
    collectResult("post_rst", 0);
    checkOutput("post_rst_const", a_out, 90);

    qa = '{16'sd384, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    qw = '{16'sd512, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    qy = model(qa, qw, 64, 2'b00, 8, 2, qs);
    q_a[0] = qa[0]; q_a[1] = qa[1];
    q_w[0] = qw[0]; q_w[1] = qw[1];
    q_bias     = 16'sd64;
    q_act      = 2'b00;
    q_valid_in = 1'b1;
    @(posedge clk);
    #1;
    q_valid_in = 1'b0;
    q_a[0] = 16'sh7fff;
    q_bias = -16'sd1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!q_valid_out && lat < 40);
    checkOutput("q8_latency", lat, QNCYC + 2);
    checkOutput("q8_a_out", q_a_out, qy);
    checkOutput("q8_a_out_const", q_a_out, 832);
    checkOutput("q8_sat", q_sat, qs);
    @(posedge clk);
    #1;
    checkOutput("q8_hs_valid", q_valid_out, 0);

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
